// File: rtl/systolic_sched_pkg.sv
// Shared definitions for the systolic array scheduler.
// Contents: top-level and stream-feeder state encodings, and the length of
// the array clear pulse (CLEAR_CYCLES) with its terminal counter value.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    CLEAR     = 3'd2,
    RUN       = 3'd3,
    WAIT_CMPL = 3'd4,
    DRAIN     = 3'd5,
    FIN       = 3'd6
  } top_state_e;

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_LOAD = 3'd1,
    F_PUSH = 3'd2,
    F_REL  = 3'd3,
    F_DONE = 3'd4
  } feed_state_e;

  localparam int         CLEAR_CYCLES = 2;
  localparam logic [1:0] CLR_LAST     = 2'(CLEAR_CYCLES - 1);

endpackage

// File: rtl/sched_stream.sv
// Stream feeder: splits one stream's row total into chunks of at most
// BUFFER_SZ rows; for each chunk it requests the loader, then pushes the
// chunk into the array, then waits for the push handshake to release.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start_i, total_i      begin a stream of total_i rows (total_i != 0)
//   load_req_o/len_o/ack_i loader handshake for the current chunk
//   wen_o, buffer_index_o, in_total_o, pushed_i   array push handshake
//   done_o                all rows of the stream have been pushed
module sched_stream
  import systolic_pkg::*;
#(
  parameter int BUFFER_SZ    = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int STREAM_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [STREAM_WIDTH-1:0] total_i,
  output logic                    load_req_o,
  output logic [INDEX_WIDTH-1:0]  load_len_o,
  input  logic                    load_ack_i,
  output logic                    wen_o,
  output logic [INDEX_WIDTH-1:0]  buffer_index_o,
  output logic [STREAM_WIDTH-1:0] in_total_o,
  input  logic                    pushed_i,
  output logic                    done_o
);

  localparam logic [STREAM_WIDTH-1:0] BUF_S = STREAM_WIDTH'(BUFFER_SZ);
  localparam logic [INDEX_WIDTH-1:0]  BUF_L = INDEX_WIDTH'(BUFFER_SZ);

  feed_state_e             state_q, state_d;
  logic [STREAM_WIDTH-1:0] rem_q, rem_d, tot_q, tot_d;
  logic [INDEX_WIDTH-1:0]  len_q, len_d;
  logic                    load_req_q, load_req_d, wen_q, wen_d;

  // Chunk length for a given number of remaining rows.
  function automatic logic [INDEX_WIDTH-1:0] chunk(input logic [STREAM_WIDTH-1:0] r);
    if (r > BUF_S) chunk = BUF_L;
    else           chunk = r[INDEX_WIDTH-1:0];
  endfunction

  // Next-state and chunk bookkeeping.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tot_d   = tot_q;
    len_d   = len_q;
    case (state_q)
      F_IDLE, F_DONE: begin
        if (start_i) begin
          tot_d   = total_i;
          rem_d   = total_i;
          len_d   = chunk(total_i);
          state_d = F_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      F_LOAD: begin
        if (load_ack_i) state_d = F_PUSH;
        else            state_d = F_LOAD;
      end
      F_PUSH: begin
        if (pushed_i) state_d = F_REL;
        else          state_d = F_PUSH;
      end
      F_REL: begin
        if (!pushed_i) begin
          // Saturating subtract: remaining never wraps below zero.
          if (rem_q > STREAM_WIDTH'(len_q)) rem_d = rem_q - STREAM_WIDTH'(len_q);
          else                              rem_d = {STREAM_WIDTH{1'b0}};
          if (rem_d == {STREAM_WIDTH{1'b0}}) begin
            state_d = F_DONE;
          end else begin
            len_d   = chunk(rem_d);
            state_d = F_LOAD;
          end
        end else begin
          state_d = F_REL;
        end
      end
      default: state_d = F_IDLE;
    endcase
    load_req_d = (state_d == F_LOAD);
    wen_d      = (state_d == F_PUSH);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= F_IDLE;
      rem_q      <= {STREAM_WIDTH{1'b0}};
      tot_q      <= {STREAM_WIDTH{1'b0}};
      len_q      <= {INDEX_WIDTH{1'b0}};
      load_req_q <= 1'b0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tot_q      <= tot_d;
      len_q      <= len_d;
      load_req_q <= load_req_d;
      wen_q      <= wen_d;
    end
  end

  assign load_req_o     = load_req_q;
  assign load_len_o     = len_q;
  // The array raises pushed in response to wen; gating keeps the two from
  // ever being seen high together.
  assign wen_o          = wen_q & ~pushed_i;
  assign buffer_index_o = len_q;
  assign in_total_o     = tot_q;
  assign done_o         = (state_q == F_DONE);

endmodule

// File: rtl/systolic_sched.sv
// Systolic array job scheduler. Latches a job, validates it, clears the
// array for CLEAR_CYCLES cycles, feeds the up and left streams in parallel,
// waits for the array to complete, hands the accumulators to the drain
// side, then pulses done.
// Ports: clk/reset (async active-high); job: start, total_up/left,
// compact_en_up/left, busy, done, cfg_err; loader: load_req/len/ack per
// stream; array: sys_resetn, sys_en, wen/buffer_index/in_total/pushed per
// stream, complete, pe_en_up/left, compact_en_up_o/left_o; drain:
// acc_valid, acc_taken.
// Optional feature: define SYSTOLIC_SCHED_TIMEOUT_EN to add a watchdog that
// aborts WAIT_CMPL with cfg_err after TIMEOUT_CYCLES cycles.
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM      = 32,
  parameter int DIM_WIDTH      = 5,
  parameter int BUFFER_SZ      = 32,
  parameter int INDEX_WIDTH    = 6,
  parameter int STREAM_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [STREAM_WIDTH-1:0] total_up,
  input  logic [STREAM_WIDTH-1:0] total_left,
  input  logic [DIM_WIDTH-2:0]    compact_en_up,
  input  logic [DIM_WIDTH-2:0]    compact_en_left,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    load_req_up,
  output logic [INDEX_WIDTH-1:0]  load_len_up,
  input  logic                    load_ack_up,
  output logic                    load_req_left,
  output logic [INDEX_WIDTH-1:0]  load_len_left,
  input  logic                    load_ack_left,
  output logic                    sys_resetn,
  output logic                    sys_en,
  output logic                    wen_up,
  output logic                    wen_left,
  output logic [INDEX_WIDTH-1:0]  buffer_index_up,
  output logic [INDEX_WIDTH-1:0]  buffer_index_left,
  output logic [STREAM_WIDTH-1:0] in_total_up,
  output logic [STREAM_WIDTH-1:0] in_total_left,
  input  logic                    pushed_up,
  input  logic                    pushed_left,
  input  logic                    complete,
  output logic [ARRAY_DIM-1:0]    pe_en_up,
  output logic [ARRAY_DIM-1:0]    pe_en_left,
  output logic [DIM_WIDTH-2:0]    compact_en_up_o,
  output logic [DIM_WIDTH-2:0]    compact_en_left_o,
  output logic                    acc_valid,
  input  logic                    acc_taken
);

  top_state_e              state_q, state_d;
  logic [STREAM_WIDTH-1:0] tu_q, tu_d, tl_q, tl_d;
  logic [DIM_WIDTH-2:0]    cu_q, cu_d, cl_q, cl_d;
  logic [ARRAY_DIM-1:0]    peu_q, peu_d, pel_q, pel_d;
  logic [1:0]              clr_q, clr_d;
  logic                    cmpl_seen_q, cmpl_seen_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                    rstn_q, rstn_d, sys_en_q, sys_en_d, accv_q, accv_d;
  logic                    feed_start_s, fup_done_s, flf_done_s, to_hit_s;

  // Bit k enabled iff k < 4*c; the loop bound caps it at ARRAY_DIM.
  function automatic logic [ARRAY_DIM-1:0] pe_mask(input logic [DIM_WIDTH-2:0] c);
    pe_mask = {ARRAY_DIM{1'b0}};
    for (int k = 0; k < ARRAY_DIM; k++) pe_mask[k] = (k < int'({c, 2'b00}));
  endfunction

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Watchdog counts cycles spent in WAIT_CMPL, restarting on every entry.
  always_comb begin
    if (state_q == WAIT_CMPL) to_cnt_d = to_cnt_q + TO_W'(1);
    else                      to_cnt_d = {TO_W{1'b0}};
    to_hit_s = (state_q == WAIT_CMPL) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_q <= {TO_W{1'b0}};
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit_s = 1'b0;
`endif

  // Top-level next state, job latching and registered-output next values.
  always_comb begin
    state_d      = state_q;
    tu_d         = tu_q;
    tl_d         = tl_q;
    cu_d         = cu_q;
    cl_d         = cl_q;
    peu_d        = peu_q;
    pel_d        = pel_q;
    clr_d        = clr_q;
    cmpl_seen_d  = cmpl_seen_q;
    err_d        = 1'b0;
    feed_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tu_d    = total_up;
          tl_d    = total_left;
          cu_d    = compact_en_up;
          cl_d    = compact_en_left;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if ((tu_q == {STREAM_WIDTH{1'b0}}) || (tl_q == {STREAM_WIDTH{1'b0}}) ||
            (cu_q == {(DIM_WIDTH-1){1'b0}}) || (cl_q == {(DIM_WIDTH-1){1'b0}})) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          peu_d   = pe_mask(cu_q);
          pel_d   = pe_mask(cl_q);
          clr_d   = 2'd0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cmpl_seen_d = 1'b0;
        if (clr_q == CLR_LAST) begin
          feed_start_s = 1'b1;
          state_d      = RUN;
        end else begin
          clr_d = clr_q + 2'd1;
        end
      end
      RUN: begin
        // An early complete is remembered and honoured in WAIT_CMPL.
        if (complete) cmpl_seen_d = 1'b1;
        else          cmpl_seen_d = cmpl_seen_q;
        if (fup_done_s && flf_done_s) state_d = WAIT_CMPL;
        else                          state_d = RUN;
      end
      WAIT_CMPL: begin
        if (complete || cmpl_seen_q) begin
          state_d = DRAIN;
        end else if (to_hit_s) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = WAIT_CMPL;
        end
      end
      DRAIN: begin
        if (acc_taken) state_d = FIN;
        else           state_d = DRAIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = state_d inside {CHECK, CLEAR, RUN, WAIT_CMPL, DRAIN};
    done_d   = (state_d == FIN);
    rstn_d   = (state_d != CLEAR);
    sys_en_d = (state_d == RUN) || (state_d == WAIT_CMPL);
    accv_d   = (state_d == DRAIN);
  end

  // State, job and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tu_q        <= {STREAM_WIDTH{1'b0}};
      tl_q        <= {STREAM_WIDTH{1'b0}};
      cu_q        <= {(DIM_WIDTH-1){1'b0}};
      cl_q        <= {(DIM_WIDTH-1){1'b0}};
      peu_q       <= {ARRAY_DIM{1'b0}};
      pel_q       <= {ARRAY_DIM{1'b0}};
      clr_q       <= 2'd0;
      cmpl_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rstn_q      <= 1'b0;
      sys_en_q    <= 1'b0;
      accv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tu_q        <= tu_d;
      tl_q        <= tl_d;
      cu_q        <= cu_d;
      cl_q        <= cl_d;
      peu_q       <= peu_d;
      pel_q       <= pel_d;
      clr_q       <= clr_d;
      cmpl_seen_q <= cmpl_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rstn_q      <= rstn_d;
      sys_en_q    <= sys_en_d;
      accv_q      <= accv_d;
    end
  end

  sched_stream #(
    .BUFFER_SZ(BUFFER_SZ), .INDEX_WIDTH(INDEX_WIDTH), .STREAM_WIDTH(STREAM_WIDTH)
  ) u_up (
    .clk(clk), .reset(reset), .start_i(feed_start_s), .total_i(tu_q),
    .load_req_o(load_req_up), .load_len_o(load_len_up), .load_ack_i(load_ack_up),
    .wen_o(wen_up), .buffer_index_o(buffer_index_up), .in_total_o(in_total_up),
    .pushed_i(pushed_up), .done_o(fup_done_s)
  );

  sched_stream #(
    .BUFFER_SZ(BUFFER_SZ), .INDEX_WIDTH(INDEX_WIDTH), .STREAM_WIDTH(STREAM_WIDTH)
  ) u_left (
    .clk(clk), .reset(reset), .start_i(feed_start_s), .total_i(tl_q),
    .load_req_o(load_req_left), .load_len_o(load_len_left), .load_ack_i(load_ack_left),
    .wen_o(wen_left), .buffer_index_o(buffer_index_left), .in_total_o(in_total_left),
    .pushed_i(pushed_left), .done_o(flf_done_s)
  );

  assign busy              = busy_q;
  assign done              = done_q;
  assign cfg_err           = err_q;
  assign sys_resetn        = rstn_q;
  assign sys_en            = sys_en_q;
  assign acc_valid         = accv_q;
  assign pe_en_up          = peu_q;
  assign pe_en_left        = pel_q;
  assign compact_en_up_o   = cu_q;
  assign compact_en_left_o = cl_q;

endmodule
